arb2_sel: RTL and testbench
===========================

ARB2_SEL -- requirements
Module: arb2_sel

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of both sources and of out.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port in0, input, WIDTH: source 0 data.
REQ-005 SHALL have port in0_valid, input, 1: source 0 offers data.
REQ-006 SHALL have port in0_ready, output, 1: source 0 data accepted this cycle.
REQ-007 SHALL have ports in1, in1_valid and in1_ready: identical to REQ-004..006, for source 1.
REQ-008 SHALL have port out, output, WIDTH: registered selected data, feeding the downstream 8-bit mux data input.
REQ-009 SHALL have port sel, output, 1: registered origin of out, 1 = source 0, 0 = source 1; matches the downstream mux polarity.
REQ-010 SHALL have port out_valid, output, 1: out and sel hold a valid entry.
REQ-011 SHALL have port out_ready, input, 1: consumer takes the entry this cycle.

Function
REQ-012 SHALL implement a one-entry output register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 SHALL compute load_ok = EMPTY or (FULL and out_ready).
REQ-014 SHALL drive inX_ready combinationally as load_ok and inX_valid and grant-to-X.
REQ-015 SHALL keep at most one inX_ready high in any cycle.
REQ-016 SHALL, on accept, register the granted data into out and set sel, with out_valid high on the next cycle (latency 1).
REQ-017 SHALL grant the only valid source when only one source is valid.
REQ-018 SHALL, when both sources are valid, grant the source not granted last (round-robin pointer last_gnt).
REQ-019 SHALL initialise last_gnt to source 1, so source 0 wins the first tie.
REQ-020 SHALL update last_gnt only on an accept.
REQ-021 SHALL transition EMPTY->FULL on accept.
REQ-022 SHALL transition FULL->EMPTY on out_ready with no accept.
REQ-023 SHALL remain FULL on out_ready with a simultaneous accept, loading new data with no bubble, sustaining one transfer per cycle.
REQ-024 SHALL hold out, sel and out_valid stable and keep both readies low when FULL and out_ready=0 (backpressure).
REQ-025 SHALL ignore out_ready while EMPTY.
REQ-026 SHALL not register data when inX_valid is low, whatever the value on inX.

Reset
REQ-027 SHALL, while rst_n=0, force out=0, sel=0, out_valid=0, in0_ready=0, in1_ready=0, state=EMPTY and last_gnt=source 1.
REQ-028 SHALL, when rst_n is asserted mid-transfer, discard the held entry with no output, and SHALL accept on the first clock edge after release.

Configuration
REQ-029 SHALL honour macro ARB2_FIXED_PRIO_EN: when defined, source 0 always wins ties and last_gnt is not implemented; when undefined, round-robin per REQ-018..020 applies.

Structure
REQ-030 SHALL place in shared package arb2_pkg: the state type (EMPTY, FULL), the source encoding constants (SRC0=1'b1, SRC1=1'b0) and the default width constant 8.
REQ-031 SHALL implement grant computation as sub-module arb2_grant (combinational: valids, last_gnt -> grant vector); the register and state logic stay in arb2_sel.

Verification
REQ-032 SHALL cover single source: in0=8'hA5, in0_valid=1, out_ready=1 -> in0_ready=1 that cycle; next cycle out=8'hA5, sel=1, out_valid=1.
REQ-033 SHALL cover tie after reset: both valid (in0=8'h11, in1=8'h22), out_ready=1 held -> outputs 11,22,11,22 on consecutive cycles, sel toggling 1,0,1,0; with ARB2_FIXED_PRIO_EN, 11 every cycle and in1_ready never high.
REQ-034 SHALL cover backpressure: FULL with out=8'h3C, out_ready=0 for 5 cycles with both sources valid -> out stays 8'h3C, both readies 0; out_ready=1 -> same-cycle accept, new data next cycle.
REQ-035 SHALL cover drain: FULL, out_ready=1, no valid inputs -> out_valid=0 next cycle, out keeps last value.
REQ-036 SHALL cover reset mid-operation: FULL with 8'h77, pulse rst_n low between edges -> out=0, sel=0, out_valid=0 immediately; after release, a tie grants source 0 first.
REQ-037 SHALL cover the one-hot check: random valids and out_ready over 1000 cycles -> in0_ready and in1_ready never both 1, and no accepted byte lost or duplicated at out (scoreboard).

Source files
------------

// File: rtl/arb2_pkg.sv
// Shared types and constants for the two-source arbiter/selector.
package arb2_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Source encoding matches the downstream mux select polarity.
    localparam logic SRC0 = 1'b1;
    localparam logic SRC1 = 1'b0;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/arb2_grant.sv
// Combinational grant for two sources; round-robin on ties unless ARB2_FIXED_PRIO_EN
// is defined, in which case source 0 always wins.
module arb2_grant
    import arb2_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
`ifndef ARB2_FIXED_PRIO_EN
    input  logic       last_gnt,
`endif
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (valid0 && valid1) begin
`ifdef ARB2_FIXED_PRIO_EN
            gnt = 2'b01;
`else
            // Tie: the source not served last goes next.
            gnt = (last_gnt == SRC1) ? 2'b01 : 2'b10;
`endif
        end else if (valid0) begin
            gnt = 2'b01;
        end else if (valid1) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/arb2_sel.sv
// Two-source arbiter feeding a one-entry output register with ready/valid handshake.
// Optional fixed-priority build: define ARB2_FIXED_PRIO_EN.
module arb2_sel
    import arb2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out,
    output logic             sel,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t     state;
    state_t     state_next;
    logic       load_ok;
    logic       accept;
    logic [1:0] gnt;

`ifdef ARB2_FIXED_PRIO_EN
    arb2_grant u_grant (
        .valid0 (in0_valid),
        .valid1 (in1_valid),
        .gnt    (gnt)
    );
`else
    logic last_gnt;

    arb2_grant u_grant (
        .valid0   (in0_valid),
        .valid1   (in1_valid),
        .last_gnt (last_gnt),
        .gnt      (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= SRC1;
        end else if (accept) begin
            last_gnt <= gnt[0] ? SRC0 : SRC1;
        end
    end
`endif

    // Readies are gated by rst_n so nothing is offered while reset is held.
    assign load_ok   = (state == EMPTY) || out_ready;
    assign in0_ready = rst_n && load_ok && gnt[0];
    assign in1_ready = rst_n && load_ok && gnt[1];
    assign accept    = in0_ready || in1_ready;
    assign out_valid = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (out_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
            sel <= 1'b0;
        end else if (accept) begin
            out <= gnt[0] ? in0 : in1;
            sel <= gnt[0] ? SRC0 : SRC1;
        end
    end

endmodule

// File: tb/tb_arb2_sel.sv
// Table-driven bench for arb2_sel plus reset, and a randomized one-hot/scoreboard run.
module tb_arb2_sel;

    logic       clk;
    logic       rst_n;
    logic [7:0] in0;
    logic       in0_valid;
    logic       in0_ready;
    logic [7:0] in1;
    logic       in1_valid;
    logic       in1_ready;
    logic [7:0] out;
    logic       sel;
    logic       out_valid;
    logic       out_ready;

    int checks;
    int failures;

    arb2_sel #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (in0),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1       (in1),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .out       (out),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] d0;
        logic       v0;
        logic [7:0] d1;
        logic       v1;
        logic       ordy;
        logic       r0;
        logic       r1;
        logic [7:0] dout;
        logic       dsel;
        logic       dov;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string name, input logic [7:0] d0, input logic v0,
                                input logic [7:0] d1, input logic v1, input logic ordy,
                                input logic r0, input logic r1, input logic [7:0] dout,
                                input logic dsel, input logic dov);
        vec_t v;
        v.name = name; v.d0 = d0; v.v0 = v0; v.d1 = d1; v.v1 = v1; v.ordy = ordy;
        v.r0 = r0; v.r1 = r1; v.dout = dout; v.dsel = dsel; v.dov = dov;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    logic [7:0] sb_q[$];
    logic       sb_sel_q[$];

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        in0 = 8'h5A; in1 = 8'hC3;
        in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;

        // Reset state, with both sources offering data.
        #2;
        chk("rst_out", out, 8'h00);
        chk("rst_sel", sel, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in0_ready", in0_ready, 1'b0);
        chk("rst_in1_ready", in1_ready, 1'b0);
        in0_valid = 1'b0; in1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Tie after reset: alternating grants starting with source 0.
`ifdef ARB2_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) add("tie", 8'h11, 1, 8'h22, 1, 1, 1, 0, 8'h11, 1, 1);
        add("bp_load", 8'h3C, 1, 8'h00, 0, 1, 1, 0, 8'h3C, 1, 1);
        for (int i = 0; i < 5; i++) add("bp_hold", 8'h44, 1, 8'h55, 1, 0, 0, 0, 8'h3C, 1, 1);
        add("bp_release", 8'h44, 1, 8'h55, 1, 1, 1, 0, 8'h44, 1, 1);
        add("drain", 8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h44, 1, 0);
        add("empty_ignore", 8'hFF, 0, 8'hEE, 0, 1, 0, 0, 8'h44, 1, 0);
`else
        add("tie0", 8'h11, 1, 8'h22, 1, 1, 1, 0, 8'h11, 1, 1);
        add("tie1", 8'h11, 1, 8'h22, 1, 1, 0, 1, 8'h22, 0, 1);
        add("tie2", 8'h11, 1, 8'h22, 1, 1, 1, 0, 8'h11, 1, 1);
        add("tie3", 8'h11, 1, 8'h22, 1, 1, 0, 1, 8'h22, 0, 1);
        add("bp_load", 8'h3C, 1, 8'h00, 0, 1, 1, 0, 8'h3C, 1, 1);
        for (int i = 0; i < 5; i++) add("bp_hold", 8'h44, 1, 8'h55, 1, 0, 0, 0, 8'h3C, 1, 1);
        add("bp_release", 8'h44, 1, 8'h55, 1, 1, 0, 1, 8'h55, 0, 1);
        add("drain", 8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h55, 0, 0);
        add("empty_ignore", 8'hFF, 0, 8'hEE, 0, 1, 0, 0, 8'h55, 0, 0);
`endif
        add("src1_only", 8'h00, 0, 8'h5A, 1, 0, 0, 1, 8'h5A, 0, 1);
        add("full_hold", 8'h01, 1, 8'h00, 0, 0, 0, 0, 8'h5A, 0, 1);
        add("src0_only", 8'hA5, 1, 8'h00, 0, 1, 1, 0, 8'hA5, 1, 1);

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            in0 = vecs[i].d0; in0_valid = vecs[i].v0;
            in1 = vecs[i].d1; in1_valid = vecs[i].v1;
            out_ready = vecs[i].ordy;
            #1;
            chk({vecs[i].name, "_in0_ready"}, in0_ready, vecs[i].r0);
            chk({vecs[i].name, "_in1_ready"}, in1_ready, vecs[i].r1);
            @(posedge clk); #1;
            chk({vecs[i].name, "_out"}, out, vecs[i].dout);
            chk({vecs[i].name, "_sel"}, sel, vecs[i].dsel);
            chk({vecs[i].name, "_out_valid"}, out_valid, vecs[i].dov);
        end

        // Reset pulse while holding 8'h77; last grant before reset was source 0.
        in0 = 8'h77; in0_valid = 1'b1; in1_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("mid_load_out", out, 8'h77);
        in0 = 8'h11; in1 = 8'h22; in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out", out, 8'h00);
        chk("mid_rst_sel", sel, 1'b0);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_in0_ready", in0_ready, 1'b0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in0_ready", in0_ready, 1'b1);
        chk("post_rst_in1_ready", in1_ready, 1'b0);
        @(posedge clk); #1;
        chk("post_rst_out", out, 8'h11);
        chk("post_rst_sel", sel, 1'b1);
        chk("post_rst_out_valid", out_valid, 1'b1);

        // Random traffic with a scoreboard; the held 8'h11 entry is already outstanding.
        sb_q.push_back(8'h11);
        sb_sel_q.push_back(1'b1);
        for (int c = 0; c < 1010; c++) begin
            if (c < 1000) begin
                in0 = 8'($urandom_range(0, 255));
                in1 = 8'($urandom_range(0, 255));
                in0_valid = 1'($urandom_range(0, 1));
                in1_valid = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
            end
            #1;
            chk("rand_one_hot", {31'd0, in0_ready && in1_ready}, 32'd0);
            chk("rand_out_valid", out_valid, (sb_q.size() != 0));
            if (out_valid && out_ready && sb_q.size() != 0) begin
                chk("rand_out", out, sb_q.pop_front());
                chk("rand_sel", sel, sb_sel_q.pop_front());
            end
            if (in0_ready) begin
                sb_q.push_back(in0);
                sb_sel_q.push_back(1'b1);
            end else if (in1_ready) begin
                sb_q.push_back(in1);
                sb_sel_q.push_back(1'b0);
            end
            @(posedge clk); #1;
        end
        chk("sb_drained", sb_q.size(), 0);
        chk("final_out_valid", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
